// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding (common to ALU, decoder and arbiter),
// arbiter state encoding and the default datapath width.
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [3:0] ALU_OP_ADD    = 4'b0000;
   localparam logic [3:0] ALU_OP_SUB    = 4'b0001;
   localparam logic [3:0] ALU_OP_AND    = 4'b0010;
   localparam logic [3:0] ALU_OP_OR     = 4'b0011;
   localparam logic [3:0] ALU_OP_XOR    = 4'b0100;
   localparam logic [3:0] ALU_OP_SLT    = 4'b0101;
   localparam logic [3:0] ALU_OP_SLTU   = 4'b0110;
   localparam logic [3:0] ALU_OP_SLL    = 4'b0111;
   localparam logic [3:0] ALU_OP_SRL    = 4'b1000;
   localparam logic [3:0] ALU_OP_SRA    = 4'b1001;
   localparam logic [3:0] ALU_OP_ANDNOT = 4'b1010;
   localparam logic [3:0] ALU_OP_NOP    = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu_arb_starve_ctr.sv
// Saturating count of requester-0 wins while requester 1 is waiting.
// at_limit tells the arbiter that requester 1 must win the next contested grant.
module alu_arb_starve_ctr
   import alu_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Clear wins over increment; the count sticks at LIMIT until cleared.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 4'd0;
      end else if (inc && (cnt_q != 4'(LIMIT))) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q == 4'(LIMIT));

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (r0) and the CSR
// unit (r1). Fixed priority to r0 with starvation relief for r1; operands
// are registered before the ALU and the result is registered after it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | accepting requests; ready is offered to the granted requester
// EXEC    | operand registers drive the ALU; result captured at cycle end
// RESP    | owner's rsp_valid high, result held until owner takes it
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset_n,

   input  logic            r0_valid,
   output logic            r0_ready,
   input  logic [3:0]      r0_alu_op,
   input  logic [XLEN-1:0] r0_src_a,
   input  logic [XLEN-1:0] r0_src_b,
   output logic            r0_rsp_valid,
   input  logic            r0_rsp_ready,
   output logic [XLEN-1:0] r0_rsp_result,
   output logic            r0_rsp_zero,

   input  logic            r1_valid,
   output logic            r1_ready,
   input  logic [3:0]      r1_alu_op,
   input  logic [XLEN-1:0] r1_src_a,
   input  logic [XLEN-1:0] r1_src_b,
   output logic            r1_rsp_valid,
   input  logic            r1_rsp_ready,
   output logic [XLEN-1:0] r1_rsp_result,
   output logic            r1_rsp_zero,

   input  logic            flush,

   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] alu_src_a,
   output logic [XLEN-1:0] alu_src_b,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,

   output logic            busy
);

   arb_state_e      state_q, state_d;
   logic            owner_q, owner_d;
   logic [3:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            zero_q, zero_d;

   logic            r0_req;
   logic            grant0;
   logic            grant1;
   logic            starve_inc;
   logic            starve_clr;
   logic            starve_hit;

   alu_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .at_limit (starve_hit)
   );

   // Arbitration, next-state and response-channel logic.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      zero_d       = zero_q;
      r0_ready     = 1'b0;
      r1_ready     = 1'b0;
      r0_rsp_valid = 1'b0;
      r1_rsp_valid = 1'b0;
      grant0       = 1'b0;
      grant1       = 1'b0;
      starve_inc   = 1'b0;
      starve_clr   = 1'b0;
      r0_req       = r0_valid && !flush;

      unique case (state_q)
         ST_IDLE: begin
            grant1     = r1_valid && (!r0_req || starve_hit);
            grant0     = r0_req && !grant1;
            r0_ready   = grant0;
            r1_ready   = grant1;
            starve_inc = grant0 && r1_valid;
            starve_clr = grant1 || !r1_valid;
            if (grant0) begin
               owner_d = 1'b0;
               op_d    = r0_alu_op;
               a_d     = r0_src_a;
               b_d     = r0_src_b;
               state_d = ST_EXEC;
            end else if (grant1) begin
               owner_d = 1'b1;
               op_d    = r1_alu_op;
               a_d     = r1_src_a;
               b_d     = r1_src_b;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!owner_q && flush) begin
               state_d = ST_IDLE;
            end else begin
               res_d   = alu_result;
               zero_d  = alu_zero;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (!owner_q) begin
               // A flush withdraws the r0 response in the same cycle.
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  r0_rsp_valid = 1'b1;
                  if (r0_rsp_ready) begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               r1_rsp_valid = 1'b1;
               if (r1_rsp_ready) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operand and response registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         op_q    <= ALU_OP_NOP;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
      end
   end

   // Operand registers only change on a grant, so the ALU inputs hold their
   // last values outside EXEC without extra muxing.
   assign alu_op        = op_q;
   assign alu_src_a     = a_q;
   assign alu_src_b     = b_q;

   assign r0_rsp_result = res_q;
   assign r0_rsp_zero   = zero_q;
   assign r1_rsp_result = res_q;
   assign r1_rsp_zero   = zero_q;

   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the external ALU.
module tb_alu_arbiter;

   localparam int XLEN = 32;

   logic            clk;
   logic            reset_n;
   logic            r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_zero;
   logic [3:0]      r0_alu_op;
   logic [XLEN-1:0] r0_src_a, r0_src_b, r0_rsp_result;
   logic            r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_zero;
   logic [3:0]      r1_alu_op;
   logic [XLEN-1:0] r1_src_a, r1_src_b, r1_rsp_result;
   logic            flush;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_src_a, alu_src_b, alu_result;
   logic            alu_zero;
   logic            busy;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_alu_op(r0_alu_op),
      .r0_src_a(r0_src_a), .r0_src_b(r0_src_b), .r0_rsp_valid(r0_rsp_valid),
      .r0_rsp_ready(r0_rsp_ready), .r0_rsp_result(r0_rsp_result), .r0_rsp_zero(r0_rsp_zero),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_alu_op(r1_alu_op),
      .r1_src_a(r1_src_a), .r1_src_b(r1_src_b), .r1_rsp_valid(r1_rsp_valid),
      .r1_rsp_ready(r1_rsp_ready), .r1_rsp_result(r1_rsp_result), .r1_rsp_zero(r1_rsp_zero),
      .flush(flush), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External RV32I ALU model.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         4'b0000: alu_result = alu_src_a + alu_src_b;
         4'b0001: alu_result = alu_src_a - alu_src_b;
         4'b0010: alu_result = alu_src_a & alu_src_b;
         4'b0011: alu_result = alu_src_a | alu_src_b;
         4'b0100: alu_result = alu_src_a ^ alu_src_b;
         4'b0101: alu_result = {31'd0, $signed(alu_src_a) < $signed(alu_src_b)};
         4'b0110: alu_result = {31'd0, alu_src_a < alu_src_b};
         4'b0111: alu_result = alu_src_a << alu_src_b[4:0];
         4'b1000: alu_result = alu_src_a >> alu_src_b[4:0];
         4'b1001: alu_result = $signed(alu_src_a) >>> alu_src_b[4:0];
         4'b1010: alu_result = alu_src_a & ~alu_src_b;
         4'b1111: alu_result = alu_src_a;
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0;
      r0_valid = 1'b0; r0_alu_op = 4'h0; r0_src_a = '0; r0_src_b = '0; r0_rsp_ready = 1'b0;
      r1_valid = 1'b0; r1_alu_op = 4'h0; r1_src_a = '0; r1_src_b = '0; r1_rsp_ready = 1'b0;
      #12;
      chk("rst_alu_op", 32'(alu_op), 32'hF);
      chk("rst_src_a", alu_src_a, 32'h0);
      chk("rst_src_b", alu_src_b, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_r0_rsp_valid", 32'(r0_rsp_valid), 32'h0);
      chk("rst_r1_rsp_valid", 32'(r1_rsp_valid), 32'h0);
      chk("rst_result", r0_rsp_result, 32'h0);
      reset_n = 1'b1;
      tick();

      // r0 only: ADD 5+7
      r0_valid = 1'b1; r0_alu_op = 4'h0; r0_src_a = 32'd5; r0_src_b = 32'd7;
      #1;
      chk("add_r0_ready", 32'(r0_ready), 32'h1);
      chk("add_r1_ready", 32'(r1_ready), 32'h0);
      tick();
      r0_valid = 1'b0;
      chk("add_exec_busy", 32'(busy), 32'h1);
      chk("add_exec_src_a", alu_src_a, 32'd5);
      chk("add_exec_op", 32'(alu_op), 32'h0);
      tick();
      chk("add_rsp_valid", 32'(r0_rsp_valid), 32'h1);
      chk("add_rsp_result", r0_rsp_result, 32'd12);
      chk("add_rsp_zero", 32'(r0_rsp_zero), 32'h0);
      chk("add_r1_rsp_valid", 32'(r1_rsp_valid), 32'h0);
      r0_rsp_ready = 1'b1;
      tick();
      r0_rsp_ready = 1'b0;
      chk("add_done_busy", 32'(busy), 32'h0);
      chk("add_done_rsp_valid", 32'(r0_rsp_valid), 32'h0);

      // Starvation: r0 SUB 3-3 and r1 ANDNOT both held valid
      r0_valid = 1'b1; r0_alu_op = 4'h1; r0_src_a = 32'd3; r0_src_b = 32'd3;
      r1_valid = 1'b1; r1_alu_op = 4'hA; r1_src_a = 32'hFF; r1_src_b = 32'h0F;
      r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("starve_r0_ready", 32'(r0_ready), 32'h1);
         chk("starve_r1_ready", 32'(r1_ready), 32'h0);
         tick();
         tick();
         chk("starve_r0_rsp_valid", 32'(r0_rsp_valid), 32'h1);
         chk("starve_r0_result", r0_rsp_result, 32'h0);
         chk("starve_r0_zero", 32'(r0_rsp_zero), 32'h1);
         tick();
      end
      chk("starve_forced_r1_ready", 32'(r1_ready), 32'h1);
      chk("starve_forced_r0_ready", 32'(r0_ready), 32'h0);
      tick();
      tick();
      chk("starve_r1_rsp_valid", 32'(r1_rsp_valid), 32'h1);
      chk("starve_r1_result", r1_rsp_result, 32'hF0);
      chk("starve_r0_rsp_valid_off", 32'(r0_rsp_valid), 32'h0);
      tick();
      chk("starve_cleared_r0_wins", 32'(r0_ready), 32'h1);
      r0_valid = 1'b0; r1_valid = 1'b0;
      r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
      tick();

      // Backpressure: SRA 0x80000000 by 0, r1 waiting meanwhile
      r0_valid = 1'b1; r0_alu_op = 4'h9; r0_src_a = 32'h8000_0000; r0_src_b = 32'd0;
      r1_valid = 1'b1; r1_alu_op = 4'hA; r1_src_a = 32'hFF; r1_src_b = 32'h0F;
      #1;
      chk("bp_r0_ready", 32'(r0_ready), 32'h1);
      tick();
      r0_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", 32'(r0_rsp_valid), 32'h1);
         chk("bp_result", r0_rsp_result, 32'h8000_0000);
         chk("bp_r1_ready", 32'(r1_ready), 32'h0);
         chk("bp_busy", 32'(busy), 32'h1);
         tick();
      end
      r0_rsp_ready = 1'b1;
      #1;
      chk("bp_release_valid", 32'(r0_rsp_valid), 32'h1);
      tick();
      r0_rsp_ready = 1'b0;
      chk("bp_r1_granted", 32'(r1_ready), 32'h1);
      tick();
      r1_valid = 1'b0;
      tick();
      chk("bp_r1_result", r1_rsp_result, 32'hF0);
      r1_rsp_ready = 1'b1;
      tick();
      r1_rsp_ready = 1'b0;

      // Flush masks r0 in IDLE
      flush = 1'b1; r0_valid = 1'b1; r0_alu_op = 4'h0; r0_src_a = 32'd1; r0_src_b = 32'd1;
      #1;
      chk("flush_idle_r0_ready", 32'(r0_ready), 32'h0);
      flush = 1'b0;
      #1;
      chk("flush_exec_r0_ready", 32'(r0_ready), 32'h1);
      tick();
      r0_valid = 1'b0; flush = 1'b1;
      chk("flush_exec_busy", 32'(busy), 32'h1);
      tick();
      flush = 1'b0;
      chk("flush_exec_idle", 32'(busy), 32'h0);
      chk("flush_exec_no_rsp", 32'(r0_rsp_valid), 32'h0);

      // Flush during RESP
      r0_valid = 1'b1; r0_alu_op = 4'h0; r0_src_a = 32'd2; r0_src_b = 32'd2;
      tick();
      r0_valid = 1'b0;
      tick();
      chk("flush_resp_valid", 32'(r0_rsp_valid), 32'h1);
      chk("flush_resp_result", r0_rsp_result, 32'd4);
      flush = 1'b1;
      #1;
      chk("flush_resp_drop", 32'(r0_rsp_valid), 32'h0);
      tick();
      flush = 1'b0;
      chk("flush_resp_idle", 32'(busy), 32'h0);

      // Flush does not touch an r1 operation
      r1_valid = 1'b1; r1_alu_op = 4'h0; r1_src_a = 32'd10; r1_src_b = 32'd20;
      #1;
      chk("flush_r1_ready", 32'(r1_ready), 32'h1);
      tick();
      r1_valid = 1'b0; flush = 1'b1;
      tick();
      chk("flush_r1_rsp_valid", 32'(r1_rsp_valid), 32'h1);
      chk("flush_r1_result", r1_rsp_result, 32'd30);
      r1_rsp_ready = 1'b1;
      tick();
      r1_rsp_ready = 1'b0; flush = 1'b0;
      chk("flush_r1_done", 32'(busy), 32'h0);

      // Async reset while in RESP
      r0_valid = 1'b1; r0_alu_op = 4'h0; r0_src_a = 32'd100; r0_src_b = 32'd1;
      tick();
      r0_valid = 1'b0;
      tick();
      chk("arst_pre_valid", 32'(r0_rsp_valid), 32'h1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_rsp_valid", 32'(r0_rsp_valid), 32'h0);
      chk("arst_alu_op", 32'(alu_op), 32'hF);
      chk("arst_src_a", alu_src_a, 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_result", r0_rsp_result, 32'h0);
      reset_n = 1'b1;
      tick();
      r1_valid = 1'b1; r1_alu_op = 4'h1; r1_src_a = 32'd9; r1_src_b = 32'd4;
      #1;
      chk("arst_r1_ready", 32'(r1_ready), 32'h1);
      tick();
      r1_valid = 1'b0;
      tick();
      chk("arst_r1_rsp_valid", 32'(r1_rsp_valid), 32'h1);
      chk("arst_r1_result", r1_rsp_result, 32'd5);
      chk("arst_r0_rsp_valid", 32'(r0_rsp_valid), 32'h0);
      r1_rsp_ready = 1'b1;
      tick();
      r1_rsp_ready = 1'b0;

      // Opcode pass-through: NOP then SLL 1<<31
      r1_valid = 1'b1; r1_alu_op = 4'hF; r1_src_a = 32'h1234; r1_src_b = 32'd0;
      tick();
      r1_valid = 1'b0;
      chk("pass_nop_op", 32'(alu_op), 32'hF);
      tick();
      chk("pass_nop_result", r1_rsp_result, 32'h1234);
      r1_rsp_ready = 1'b1;
      tick();
      r1_rsp_ready = 1'b0;
      r1_valid = 1'b1; r1_alu_op = 4'h7; r1_src_a = 32'd1; r1_src_b = 32'd31;
      tick();
      r1_valid = 1'b0;
      chk("pass_sll_op", 32'(alu_op), 32'h7);
      tick();
      chk("pass_sll_result", r1_rsp_result, 32'h8000_0000);
      chk("pass_sll_zero", 32'(r1_rsp_zero), 32'h0);
      r1_rsp_ready = 1'b1;
      tick();
      r1_rsp_ready = 1'b0;
      chk("pass_sll_done", 32'(busy), 32'h0);
      chk("pass_hold_op", 32'(alu_op), 32'h7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
